rle_capture_ctrl: RTL and testbench
===================================

# rle_capture_ctrl

Sequencer for the run-length encoder in the capture core. It decodes the channel-group flags into the encoder mode and data mask, and gates the encoder during a capture. It counts the words the encoder emits against the programmed read count, then forces a flush so a pending run count reaches sample memory before the capture is declared done. It sits between the flags/trigger logic and the encoder, on the core sample clock.

## Interface
Parameters:
- CNT_W, 16: width of the read-count limit and the emitted-word counter.
- FLUSH_TMO, 16: flush watchdog depth in cycles; used only with the timeout feature.

Ports:
- clock  in  1  core clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- arm  in  1  single-cycle pulse that starts a capture.
- rle_en  in  1  flags bit; 1 selects RLE mode, 0 passes samples through uncounted by RLE.
- disabled_groups  in  4  flags[5:2]; 1 disables that 8-bit channel group.
- triggered  in  1  level; the trigger has fired.
- read_count  in  CNT_W  number of memory words to store after the trigger.
- enc_valid_out  in  1  the encoder emitted a word this cycle.
- enc_idle  in  1  the encoder holds no pending run.
- enc_enable  out  1  encoder accepts validIn.
- enc_flush  out  1  request to emit the pending run.
- rle_mode  out  2  encoder mode; the flag bit is 7, 15, 23 or 31.
- data_mask  out  32  mask applied to encoder dataIn.
- running  out  1  high from arm until done.
- done  out  1  capture complete; sticky until the next arm or reset.
- flush_timeout  out  1  sticky error flag; only present with the timeout feature.

## Operation
States:
- IDLE: go to RUN on arm.
- RUN: increment the word counter on each enc_valid_out while triggered=1. Go to FLUSH when counter == read_count−1 and enc_valid_out. If read_count==0, go to FLUSH on the first cycle triggered=1.
- FLUSH: hold enc_flush=1 and enc_enable=0. Go to DONE on the first cycle enc_idle=1.
- DONE: done=1. Go to RUN on arm.

Rules:
- Non-RLE bypass (rle_en=0): enc_enable is held 0, enc_flush never asserts, and DONE is entered at the same counter condition as RLE mode.
- Mode decode from the number of enabled groups n (n = popcount of ~disabled_groups): n=1 gives mode 0, n=2 mode 1, n=3 mode 2, n=4 mode 3, n=0 mode 0.
- data_mask = low 8·max(n,1) bits set.
- Mode and mask are latched on arm and held for the whole capture. Flag changes mid-capture are ignored.
- Word counter is CNT_W bits, cleared on arm, saturating at all-ones (no wrap).
- arm in FLUSH or RUN is ignored.
- Arm in the same cycle as the terminating enc_valid_out: the terminating event wins; arm is ignored.

## Timing
- Reset values: state IDLE, enc_enable 0, enc_flush 0, rle_mode 0, data_mask 32'h000000FF, running 0, done 0, flush_timeout 0.
- Reset mid-capture aborts immediately to these values with no flush.
- All outputs are registered.
- enc_enable rises the cycle after arm; running rises the same cycle.
- enc_flush rises the cycle after the terminating enc_valid_out.
- done rises the cycle after enc_idle is sampled high in FLUSH.
- If enc_idle is already high on FLUSH entry, enc_flush lasts exactly 1 cycle.
- enc_valid_out seen during FLUSH (flush words) increments the counter but does not change state.

## Configuration
- RLE_CTRL_TIMEOUT_EN defined: in FLUSH, a cycle counter runs. After FLUSH_TMO cycles without enc_idle:
  - the block forces DONE;
  - sets flush_timeout (sticky; cleared by arm or reset).
- RLE_CTRL_TIMEOUT_EN undefined: FLUSH waits indefinitely, and the flush_timeout port is tied 0.

## Structure
- Shared package rle_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - the rle_mode_t 2-bit enum;
  - the GROUP_W=8 constant.
- One sub-module, rle_mode_decode: a purely combinational mapping of disabled_groups to {rle_mode, data_mask}, shared with the encoder.

## Test plan
- disabled_groups=4'b1000, rle_en=1, arm -> rle_mode=2, data_mask=32'h00FFFFFF; enc_enable high 1 cycle after arm.
- read_count=8, triggered=1, 8 enc_valid_out pulses -> enc_flush rises after the 8th pulse; enc_idle asserted 3 cycles later -> done 1 cycle after that, with counter=8 plus any flush words.
- read_count=0, triggered rises -> FLUSH on the first triggered cycle; with enc_idle=1, enc_flush is a 1-cycle pulse and done follows next cycle.
- Reset asserted while in FLUSH -> all outputs return to reset values asynchronously; a following arm starts a clean RUN with counter=0.
- rle_en=0, read_count=4 -> enc_enable stays 0, no enc_flush, and done is set after the 4th enc_valid_out.
- With RLE_CTRL_TIMEOUT_EN, FLUSH_TMO=16, enc_idle held 0 -> done and flush_timeout are set after 16 FLUSH cycles; the next arm clears flush_timeout.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE capture sequencer and the encoder mode decode.
package rle_pkg;

    localparam int GROUP_W    = 8;
    localparam int NUM_GROUPS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } rle_state_t;

    // Encoder mode: position of the run-count flag bit (7, 15, 23 or 31).
    typedef enum logic [1:0] {
        MODE_FLAG7,
        MODE_FLAG15,
        MODE_FLAG23,
        MODE_FLAG31
    } rle_mode_t;

    function automatic logic [2:0] enabled_groups(input logic [NUM_GROUPS-1:0] disabled);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            n = n + {2'b00, ~disabled[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rle_mode_decode.sv
// Combinational map from the disabled channel groups to encoder mode and data mask.
// No groups enabled behaves like a single enabled group.
module rle_mode_decode
    import rle_pkg::*;
(
    input  logic [NUM_GROUPS-1:0]         disabled_groups,
    output rle_mode_t                     rle_mode,
    output logic [NUM_GROUPS*GROUP_W-1:0] data_mask
);

    logic [2:0] n_en;

    always_comb begin
        n_en      = enabled_groups(disabled_groups);
        rle_mode  = MODE_FLAG7;
        data_mask = {{(3*GROUP_W){1'b0}}, {GROUP_W{1'b1}}};
        case (n_en)
            3'd2: begin
                rle_mode  = MODE_FLAG15;
                data_mask = {{(2*GROUP_W){1'b0}}, {(2*GROUP_W){1'b1}}};
            end
            3'd3: begin
                rle_mode  = MODE_FLAG23;
                data_mask = {{GROUP_W{1'b0}}, {(3*GROUP_W){1'b1}}};
            end
            3'd4: begin
                rle_mode  = MODE_FLAG31;
                data_mask = {(4*GROUP_W){1'b1}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rle_capture_ctrl.sv
// Capture sequencer for the RLE encoder: latches mode/mask on arm, counts emitted words,
// forces a flush of the pending run before done. Macro RLE_CTRL_TIMEOUT_EN adds a flush watchdog.
//
//   state    | meaning
//   ST_IDLE  | waiting for the first arm after reset
//   ST_RUN   | encoder enabled, counting words emitted while triggered
//   ST_FLUSH | enc_flush held, waiting for the encoder to go idle
//   ST_DONE  | capture complete, done held until the next arm
module rle_capture_ctrl
    import rle_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FLUSH_TMO = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arm,
    input  logic             rle_en,
    input  logic [3:0]       disabled_groups,
    input  logic             triggered,
    input  logic [CNT_W-1:0] read_count,
    input  logic             enc_valid_out,
    input  logic             enc_idle,
    output logic             enc_enable,
    output logic             enc_flush,
    output logic [1:0]       rle_mode,
    output logic [31:0]      data_mask,
    output logic             running,
    output logic             done,
    output logic             flush_timeout
);

    rle_state_t       state_q;
    rle_mode_t        mode_q;
    logic [31:0]      mask_q;
    logic             rle_en_q;
    logic             enc_enable_q;
    logic             enc_flush_q;
    logic             running_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    rle_mode_t        dec_mode;
    logic [31:0]      dec_mask;
    logic [CNT_W-1:0] cnt_d;
    logic             last_word;

    rle_mode_decode u_mode_decode (
        .disabled_groups (disabled_groups),
        .rle_mode        (dec_mode),
        .data_mask       (dec_mask)
    );

    // Saturating increment: a long flush tail must not wrap the word count.
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign last_word = (read_count == '0) ||
                       (enc_valid_out && (cnt_q == read_count - CNT_W'(1)));

`ifdef RLE_CTRL_TIMEOUT_EN
    localparam int TMO_W = (FLUSH_TMO > 1) ? $clog2(FLUSH_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FLUSH_TMO - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             tmo_flag_q;
`else
    logic unused_flush_tmo;
    assign unused_flush_tmo = ^FLUSH_TMO;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_FLAG7;
            mask_q       <= 32'h0000_00FF;
            rle_en_q     <= 1'b0;
            enc_enable_q <= 1'b0;
            enc_flush_q  <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
`ifdef RLE_CTRL_TIMEOUT_EN
            tmo_q        <= '0;
            tmo_flag_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_q      <= ST_RUN;
                        mode_q       <= dec_mode;
                        mask_q       <= dec_mask;
                        rle_en_q     <= rle_en;
                        enc_enable_q <= rle_en;
                        running_q    <= 1'b1;
                        done_q       <= 1'b0;
                        cnt_q        <= '0;
`ifdef RLE_CTRL_TIMEOUT_EN
                        tmo_flag_q   <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (triggered && enc_valid_out) begin
                        cnt_q <= cnt_d;
                    end
                    if (triggered && last_word) begin
                        enc_enable_q <= 1'b0;
                        // Bypass captures hold no pending run, so they skip the flush.
                        if (rle_en_q) begin
                            state_q     <= ST_FLUSH;
                            enc_flush_q <= 1'b1;
`ifdef RLE_CTRL_TIMEOUT_EN
                            tmo_q       <= '0;
`endif
                        end else begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (enc_valid_out) begin
                        cnt_q <= cnt_d;
                    end
                    if (enc_idle) begin
                        state_q     <= ST_DONE;
                        enc_flush_q <= 1'b0;
                        running_q   <= 1'b0;
                        done_q      <= 1'b1;
                    end
`ifdef RLE_CTRL_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q     <= ST_DONE;
                        enc_flush_q <= 1'b0;
                        running_q   <= 1'b0;
                        done_q      <= 1'b1;
                        tmo_flag_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign enc_enable = enc_enable_q;
    assign enc_flush  = enc_flush_q;
    assign rle_mode   = mode_q;
    assign data_mask  = mask_q;
    assign running    = running_q;
    assign done       = done_q;

`ifdef RLE_CTRL_TIMEOUT_EN
    assign flush_timeout = tmo_flag_q;
`else
    assign flush_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rle_capture_ctrl.sv
// Directed bench for rle_capture_ctrl (CNT_W=4 so the word counter can be driven to saturation).
module tb_rle_capture_ctrl;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             arm = 1'b0;
    logic             rle_en = 1'b0;
    logic [3:0]       disabled_groups = 4'b0000;
    logic             triggered = 1'b0;
    logic [CNT_W-1:0] read_count = '0;
    logic             enc_valid_out = 1'b0;
    logic             enc_idle = 1'b0;
    logic             enc_enable;
    logic             enc_flush;
    logic [1:0]       rle_mode;
    logic [31:0]      data_mask;
    logic             running;
    logic             done;
    logic             flush_timeout;

    int vectors = 0;
    int errors  = 0;

    rle_capture_ctrl #(.CNT_W(CNT_W), .FLUSH_TMO(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .arm             (arm),
        .rle_en          (rle_en),
        .disabled_groups (disabled_groups),
        .triggered       (triggered),
        .read_count      (read_count),
        .enc_valid_out   (enc_valid_out),
        .enc_idle        (enc_idle),
        .enc_enable      (enc_enable),
        .enc_flush       (enc_flush),
        .rle_mode        (rle_mode),
        .data_mask       (data_mask),
        .running         (running),
        .done            (done),
        .flush_timeout   (flush_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        tick();
        chk("rst_enable", 32'(enc_enable), 32'd0);
        chk("rst_flush", 32'(enc_flush), 32'd0);
        chk("rst_mode", 32'(rle_mode), 32'd0);
        chk("rst_mask", data_mask, 32'h0000_00FF);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(flush_timeout), 32'd0);
        reset = 1'b0;
        tick();

        // RLE capture, 3 groups, read_count=8, one flush word, arm ignored in FLUSH
        disabled_groups = 4'b1000; rle_en = 1'b1; read_count = 4'd8; arm = 1'b1;
        chk("t1_enable_before", 32'(enc_enable), 32'd0);
        tick();
        arm = 1'b0;
        chk("t1_mode", 32'(rle_mode), 32'd2);
        chk("t1_mask", data_mask, 32'h00FF_FFFF);
        chk("t1_enable", 32'(enc_enable), 32'd1);
        chk("t1_running", 32'(running), 32'd1);
        disabled_groups = 4'b0000; rle_en = 1'b0; enc_valid_out = 1'b1;
        tick();
        chk("t1_mode_held", 32'(rle_mode), 32'd2);
        chk("t1_mask_held", data_mask, 32'h00FF_FFFF);
        chk("t1_untrig_cnt", 32'(dut.cnt_q), 32'd0);
        triggered = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("t1_cnt7", 32'(dut.cnt_q), 32'd7);
        chk("t1_flush_early", 32'(enc_flush), 32'd0);
        tick();
        chk("t1_flush", 32'(enc_flush), 32'd1);
        chk("t1_enable_off", 32'(enc_enable), 32'd0);
        chk("t1_cnt8", 32'(dut.cnt_q), 32'd8);
        tick();
        chk("t1_flushword_cnt", 32'(dut.cnt_q), 32'd9);
        enc_valid_out = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t1_arm_ign_cnt", 32'(dut.cnt_q), 32'd9);
        chk("t1_arm_ign_flush", 32'(enc_flush), 32'd1);
        chk("t1_done_early", 32'(done), 32'd0);
        enc_idle = 1'b1;
        tick();
        enc_idle = 1'b0;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_flush_end", 32'(enc_flush), 32'd0);
        chk("t1_running_end", 32'(running), 32'd0);
        chk("t1_cnt_end", 32'(dut.cnt_q), 32'd9);

        // read_count=0, encoder already idle: 1-cycle flush
        triggered = 1'b0; rle_en = 1'b1; disabled_groups = 4'b0000; read_count = 4'd0; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t3_done_clr", 32'(done), 32'd0);
        chk("t3_mode", 32'(rle_mode), 32'd3);
        chk("t3_mask", data_mask, 32'hFFFF_FFFF);
        tick();
        chk("t3_wait_trig", 32'(enc_flush), 32'd0);
        triggered = 1'b1; enc_idle = 1'b1;
        tick();
        chk("t3_flush", 32'(enc_flush), 32'd1);
        tick();
        enc_idle = 1'b0;
        chk("t3_flush_1cyc", 32'(enc_flush), 32'd0);
        chk("t3_done", 32'(done), 32'd1);

        // asynchronous reset while flushing, then a clean capture
        disabled_groups = 4'b0011; read_count = 4'd2; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t4_mode", 32'(rle_mode), 32'd1);
        chk("t4_mask", data_mask, 32'h0000_FFFF);
        enc_valid_out = 1'b1;
        tick();
        tick();
        enc_valid_out = 1'b0;
        chk("t4_flush", 32'(enc_flush), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t4_async_flush", 32'(enc_flush), 32'd0);
        chk("t4_async_running", 32'(running), 32'd0);
        chk("t4_async_mode", 32'(rle_mode), 32'd0);
        chk("t4_async_mask", data_mask, 32'h0000_00FF);
        chk("t4_async_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        disabled_groups = 4'b0100; read_count = 4'd3; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t4_clean_cnt", 32'(dut.cnt_q), 32'd0);
        chk("t4_clean_mode", 32'(rle_mode), 32'd2);
        enc_valid_out = 1'b1;
        tick();
        tick();
        chk("t4_cnt2", 32'(dut.cnt_q), 32'd2);
        chk("t4_no_flush", 32'(enc_flush), 32'd0);
        tick();
        chk("t4_flush2", 32'(enc_flush), 32'd1);
        enc_valid_out = 1'b0; enc_idle = 1'b1;
        tick();
        enc_idle = 1'b0;
        chk("t4_done", 32'(done), 32'd1);

        // bypass mode, arm coinciding with the terminating word
        triggered = 1'b0; rle_en = 1'b0; disabled_groups = 4'b0000; read_count = 4'd4; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t5_enable", 32'(enc_enable), 32'd0);
        chk("t5_running", 32'(running), 32'd1);
        enc_valid_out = 1'b1;
        tick();
        chk("t5_untrig_cnt", 32'(dut.cnt_q), 32'd0);
        triggered = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_cnt3", 32'(dut.cnt_q), 32'd3);
        chk("t5_done_early", 32'(done), 32'd0);
        chk("t5_enable_run", 32'(enc_enable), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0; enc_valid_out = 1'b0;
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_flush", 32'(enc_flush), 32'd0);
        chk("t5_running_end", 32'(running), 32'd0);
        chk("t5_cnt4", 32'(dut.cnt_q), 32'd4);
        tick();
        chk("t5_done_sticky", 32'(done), 32'd1);

        // counter saturation at all-ones through flush words
        rle_en = 1'b1; read_count = 4'd15; arm = 1'b1;
        tick();
        arm = 1'b0; enc_valid_out = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("t6_flush", 32'(enc_flush), 32'd1);
        chk("t6_cnt15", 32'(dut.cnt_q), 32'd15);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_saturate", 32'(dut.cnt_q), 32'd15);
        enc_valid_out = 1'b0; enc_idle = 1'b1;
        tick();
        enc_idle = 1'b0;
        chk("t6_done", 32'(done), 32'd1);

`ifdef RLE_CTRL_TIMEOUT_EN
        // flush watchdog
        read_count = 4'd0; triggered = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        chk("t7_flush", 32'(enc_flush), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("t7_flush_15", 32'(enc_flush), 32'd1);
        chk("t7_done_early", 32'(done), 32'd0);
        tick();
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_timeout", 32'(flush_timeout), 32'd1);
        chk("t7_flush_off", 32'(enc_flush), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t7_timeout_clr", 32'(flush_timeout), 32'd0);
`else
        chk("t7_timeout_tied", 32'(flush_timeout), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
